fft_control: RTL
================

Name: fft_control

Overview:
Control sequencer for the 8-bit radix-2 butterfly datapath. It debounces the ReadyIn push-button and steps one state per accepted press. Each state drives the datapath control vector: operand load strobes, multiplier/ALU steering, accumulator store, hold/clear and output select. Instantiated beside the datapath at top level, sharing Clock, nReset and ReadyIn.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on ReadyIn (minimum 2)
DEBOUNCE, 4, consecutive stable synchronised samples required to accept a level change (minimum 1)

Ports:
Clock  in  1  system clock, all flops rising-edge
nReset  in  1  asynchronous active-low reset
ReadyIn  in  1  raw push-button, asynchronous to Clock
enReb, enImb, enRew, enImw, enRea, enIma  out  1 each  operand register load strobes; datapath captures sw on the 0->1 edge
load  out  1  allows the ReadyIn-gated accumulator store
enout  out  1  LED output enable
mux_mul  out  1  0: Reb*Rew / Imw*Reb; 1: Imb*Imw / Imb*Rew
mux_alu  out  1  0: ALU input is the product; 1: ALU input is Rea/Ima
sub1, sub2  out  2 each  00 a+b, 01 a-b, 10 b-a (a = ALU input, b = held accumulator)
out_sel  out  1  0 real lane, 1 imaginary lane
rst  out  1  active-low clear of Imb and Rea
hold  out  1  active-low clear of Ima; 1 feeds the accumulator back to the ALU
step  out  4  current state code

Behaviour:
- Reset: asynchronous active-low (fixed). On nReset=0: state=IDLE; outputs take IDLE values immediately; synchroniser, debounce counter and accepted level all cleared to 0. Reset mid-sequence aborts to IDLE.
- Input path: ReadyIn passes through SYNC_STAGES flops. A counter tracks how long the synchronised level has differed from the accepted level.
  - Counter clears whenever the synchronised level equals the accepted level.
  - When the counter reaches DEBOUNCE, the accepted level flips.
  - A 0->1 flip of the accepted level produces a one-cycle adv pulse.
- Latency: from a clean ReadyIn rise to step change is SYNC_STAGES+DEBOUNCE cycles. One press gives exactly one advance, however long it is held. A release never advances.
- Outputs are registered, decoded from next-state, and change on the same edge as step. No combinational path exists from ReadyIn to any output.
- Default output vector: all en* = 0, load = 0, enout = 0, mux_mul = 0, mux_alu = 0, sub1 = sub2 = 00, out_sel = 0, rst = 1, hold = 1.
- States (step code, deviations from the default). Each state advances to the next on adv:
  - 0 IDLE: rst=0, hold=0
  - 1 LD_REB: enReb=1, hold=0
  - 2 LD_IMB: enImb=1, hold=0
  - 3 LD_REW: enRew=1, hold=0
  - 4 LD_IMW: enImw=1, hold=0
  - 5 MUL1: load=1, hold=0
  - 6 MUL2: load=1, mux_mul=1, sub1=10, sub2=00
  - 7 LD_REA: enRea=1
  - 8 LD_IMA: enIma=1
  - 9 OUT_RE0: mux_alu=1, enout=1, out_sel=0, sub1=00
  - 10 OUT_IM0: mux_alu=1, enout=1, out_sel=1, sub2=00
  - 11 OUT_RE1: mux_alu=1, enout=1, out_sel=0, sub1=01
  - 12 OUT_IM1: mux_alu=1, enout=1, out_sel=1, sub2=01
  - OUT_IM1 returns to IDLE on adv.
  - Codes 13-15 are illegal and recover to IDLE on the next clock.
- Ordering rules (required):
  - rst deasserts at least one state before enImb/enRea rise, and hold deasserts-to-1 at least one state before enIma rises, so the cleared registers see a fresh enable edge.
  - hold stays 0 through MUL1, so the first store is product+0.
  - Operand capture occurs on state entry. The accumulator store occurs on the press that leaves MUL1 or MUL2, while that state's controls are still applied (the datapath sees ReadyIn before this block advances).
- Simultaneous nReset and adv: reset wins.

Decomposition:
- Shared package fft_pkg: state enum (4-bit, codes above), ALU op constants ADD=2'b00, SUB_AB=2'b01, SUB_BA=2'b10, and a packed control-vector struct.
- One sub-module, button_debounce (synchroniser + counter + rise pulse), parameterised by SYNC_STAGES and DEBOUNCE.

Test Plan:
- nReset=0 asserted mid-MUL2 -> same cycle: step=0, rst=0, hold=0, all en*=0, load=0, enout=0.
- ReadyIn toggling every cycle for 20 cycles, DEBOUNCE=4 -> step stays 0, no output change.
- Clean ReadyIn high for 50 cycles from IDLE -> step 0->1 exactly 6 cycles after the rise, enReb=1, rst=1, no further advance; release -> no advance.
- 13 clean presses -> step walks 1..12 then 0; each state's full control vector matches the state list; load=1 only in steps 5-6.
- Force state to 14 -> IDLE after 1 clock.
- Integrated with the datapath, sw = Reb 0x40, Imb 0x00, Rew 0x40, Imw 0x00, Rea 0x20, Ima 0x00 -> led 0x40 in OUT_RE0, 0x00 in OUT_IM0, OUT_RE1 and OUT_IM1.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the radix-2 butterfly control sequencer: state codes,
// ALU operation codes and the packed datapath control vector.
package fft_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LD_REB  = 4'd1,
    LD_IMB  = 4'd2,
    LD_REW  = 4'd3,
    LD_IMW  = 4'd4,
    MUL1    = 4'd5,
    MUL2    = 4'd6,
    LD_REA  = 4'd7,
    LD_IMA  = 4'd8,
    OUT_RE0 = 4'd9,
    OUT_IM0 = 4'd10,
    OUT_RE1 = 4'd11,
    OUT_IM1 = 4'd12
  } state_t;

  localparam logic [1:0] ADD    = 2'b00;
  localparam logic [1:0] SUB_AB = 2'b01;
  localparam logic [1:0] SUB_BA = 2'b10;

  typedef struct packed {
    logic       en_reb;
    logic       en_imb;
    logic       en_rew;
    logic       en_imw;
    logic       en_rea;
    logic       en_ima;
    logic       load;
    logic       enout;
    logic       mux_mul;
    logic       mux_alu;
    logic [1:0] sub1;
    logic [1:0] sub2;
    logic       out_sel;
    logic       rst;
    logic       hold;
  } ctrl_t;

  // Control vector applied while the sequencer sits in state s.
  // rst/hold are active-low clears, so their idle level is 1.
  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c      = '0;
    c.sub1 = ADD;
    c.sub2 = ADD;
    c.rst  = 1'b1;
    c.hold = 1'b1;
    case (s)
      IDLE: begin
        c.rst  = 1'b0;
        c.hold = 1'b0;
      end
      LD_REB: begin
        c.en_reb = 1'b1;
        c.hold   = 1'b0;
      end
      LD_IMB: begin
        c.en_imb = 1'b1;
        c.hold   = 1'b0;
      end
      LD_REW: begin
        c.en_rew = 1'b1;
        c.hold   = 1'b0;
      end
      LD_IMW: begin
        c.en_imw = 1'b1;
        c.hold   = 1'b0;
      end
      // Holding the accumulator clear through MUL1 makes the first store product+0.
      MUL1: begin
        c.load = 1'b1;
        c.hold = 1'b0;
      end
      MUL2: begin
        c.load    = 1'b1;
        c.mux_mul = 1'b1;
        c.sub1    = SUB_BA;
        c.sub2    = ADD;
      end
      LD_REA: c.en_rea = 1'b1;
      LD_IMA: c.en_ima = 1'b1;
      OUT_RE0: begin
        c.mux_alu = 1'b1;
        c.enout   = 1'b1;
        c.out_sel = 1'b0;
        c.sub1    = ADD;
      end
      OUT_IM0: begin
        c.mux_alu = 1'b1;
        c.enout   = 1'b1;
        c.out_sel = 1'b1;
        c.sub2    = ADD;
      end
      OUT_RE1: begin
        c.mux_alu = 1'b1;
        c.enout   = 1'b1;
        c.out_sel = 1'b0;
        c.sub1    = SUB_AB;
      end
      OUT_IM1: begin
        c.mux_alu = 1'b1;
        c.enout   = 1'b1;
        c.out_sel = 1'b1;
        c.sub2    = SUB_AB;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fft_control_button_debounce.sv
// Push-button front end: synchroniser chain, stability counter and a
// one-cycle pulse when the accepted level flips from 0 to 1.
module button_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_in,
  output logic adv
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE < 1) begin : g_bad_debounce
    $error("button_debounce: DEBOUNCE must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   level_q;
  logic                   synced;
  logic                   flip;

  assign synced = sync_q[SYNC_STAGES-1];

  // The flip is recognised on the DEBOUNCE-th differing sample, so the pulse is
  // combinational off flops and the sequencer moves on the same edge as level_q.
  assign flip = (synced != level_q) && (cnt_q == CW'(DEBOUNCE - 1));
  assign adv  = flip && synced;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], button_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else if (synced == level_q) begin
      cnt_q <= '0;
    end else if (flip) begin
      cnt_q   <= '0;
      level_q <= synced;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fft_control.sv
// Control sequencer for the 8-bit radix-2 butterfly datapath: one state step
// per debounced ReadyIn press, with a registered control vector per state.
module fft_control #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       ReadyIn,
  output logic       enReb,
  output logic       enImb,
  output logic       enRew,
  output logic       enImw,
  output logic       enRea,
  output logic       enIma,
  output logic       load,
  output logic       enout,
  output logic       mux_mul,
  output logic       mux_alu,
  output logic [1:0] sub1,
  output logic [1:0] sub2,
  output logic       out_sel,
  output logic       rst,
  output logic       hold,
  output logic [3:0] step
);

  import fft_pkg::*;

  logic   adv;
  state_t state_q;
  state_t state_next;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_next;

  button_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_debounce (
    .clk      (Clock),
    .rst_n    (nReset),
    .button_in(ReadyIn),
    .adv      (adv)
  );

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (adv) state_next = LD_REB;
      LD_REB:  if (adv) state_next = LD_IMB;
      LD_IMB:  if (adv) state_next = LD_REW;
      LD_REW:  if (adv) state_next = LD_IMW;
      LD_IMW:  if (adv) state_next = MUL1;
      MUL1:    if (adv) state_next = MUL2;
      MUL2:    if (adv) state_next = LD_REA;
      LD_REA:  if (adv) state_next = LD_IMA;
      LD_IMA:  if (adv) state_next = OUT_RE0;
      OUT_RE0: if (adv) state_next = OUT_IM0;
      OUT_IM0: if (adv) state_next = OUT_RE1;
      OUT_RE1: if (adv) state_next = OUT_IM1;
      OUT_IM1: if (adv) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Decoding from next-state keeps the outputs registered yet in step with state_q.
    ctrl_next = decode_ctrl(state_next);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      ctrl_q  <= decode_ctrl(IDLE);
    end else begin
      state_q <= state_next;
      ctrl_q  <= ctrl_next;
    end
  end

  assign enReb   = ctrl_q.en_reb;
  assign enImb   = ctrl_q.en_imb;
  assign enRew   = ctrl_q.en_rew;
  assign enImw   = ctrl_q.en_imw;
  assign enRea   = ctrl_q.en_rea;
  assign enIma   = ctrl_q.en_ima;
  assign load    = ctrl_q.load;
  assign enout   = ctrl_q.enout;
  assign mux_mul = ctrl_q.mux_mul;
  assign mux_alu = ctrl_q.mux_alu;
  assign sub1    = ctrl_q.sub1;
  assign sub2    = ctrl_q.sub2;
  assign out_sel = ctrl_q.out_sel;
  assign rst     = ctrl_q.rst;
  assign hold    = ctrl_q.hold;
  assign step    = state_q;

endmodule
